// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one port of the byte-addressed 32-bit dual-port RAM
// between two requesters. Byte and halfword writes are done as a read-modify-write
// of the containing word because the RAM only accepts full-word writes.
module dpram_port_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [1:0]        size0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic [31:0]       rdata0,
    output logic              ack0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic [31:0]       rdata1,
    output logic              ack1,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    state_t            state, state_next;
    logic              rr_last;
    logic              gnt_id;
    logic              id;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge;
    logic              err_q;
    logic              misaligned;
    logic              we_raw;
    logic [ADDR_W-1:0] aligned_addr;

    // Extract the addressed lane of a RAM word, zero-extended and right-justified.
    function automatic logic [31:0] read_lane(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
        logic [31:0] r;
        case (size)
            2'b00:   r = {24'd0, word[{off, 3'b000} +: 8]};
            2'b01:   r = {16'd0, word[{off[1], 4'b0000} +: 16]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or halfword lane of a RAM word with new data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] m;
        m = word;
        if (size == 2'b00)
            m[{off, 3'b000} +: 8] = wd[7:0];
        else
            m[{off[1], 4'b0000} +: 16] = wd[15:0];
        return m;
    endfunction

    // On a tie the requester that did not win last time is granted.
    assign gnt_id = (req0 && req1) ? ~rr_last : req1;

    assign misaligned = (size_q == 2'b11) ||
                        (size_q == 2'b01 && addr_q[0]) ||
                        (size_q == 2'b10 && addr_q[1:0] != 2'b00);

    assign aligned_addr = {addr_q[ADDR_W-1:2], 2'b00};

    assign ack0 = (state == DONE) && !id;
    assign ack1 = (state == DONE) && id;
    assign err0 = ack0 && err_q;
    assign err1 = ack1 && err_q;

    // Next-state and RAM-port decode; the port is idle (all zero) outside ACCESS/WRITE.
    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        we_raw     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1)
                    state_next = ACCESS;
            end
            ACCESS: begin
                state_next = DONE;
                if (!misaligned) begin
                    mem_addr = aligned_addr;
                    if (we_q && size_q == 2'b10) begin
                        we_raw    = 1'b1;
                        mem_wdata = wdata_q;
                    end else if (we_q) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_addr   = aligned_addr;
                mem_wdata  = merge;
                we_raw     = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        // A reset arriving during a write cycle must leave the RAM untouched.
        mem_we = we_raw && !p_reset;
    end

    // Control state: FSM, round-robin pointer, error flag and returned read data.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            err_q   <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (req0 || req1))
                rr_last <= gnt_id;
            if (state == ACCESS) begin
                err_q <= misaligned;
                if (!misaligned && !we_q) begin
                    if (id)
                        rdata1 <= read_lane(mem_rdata, size_q, addr_q[1:0]);
                    else
                        rdata0 <= read_lane(mem_rdata, size_q, addr_q[1:0]);
                end
            end
        end
    end

    // Request fields latched at grant, and the merged word for a partial write.
    always_ff @(posedge m_clock) begin
        if (state == IDLE && (req0 || req1)) begin
            id      <= gnt_id;
            we_q    <= gnt_id ? we1    : we0;
            size_q  <= gnt_id ? size1  : size0;
            addr_q  <= gnt_id ? addr1  : addr0;
            wdata_q <= gnt_id ? wdata1 : wdata0;
        end
        if (state == ACCESS)
            merge <= merge_lane(mem_rdata, wdata_q, size_q, addr_q[1:0]);
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: a behavioural RAM on port 2 plus a scoreboard of
// expected completions, exercised scenario by scenario.
module tb_dpram_port_arbiter;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        req0, we0, req1, we1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] ram [0:255];

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int passed = 0;
    int total  = 0;

    // Bench-side expectation of each requester's rdata register.
    logic [31:0] exp_rd0, exp_rd1;

    // Observations from the last single transaction.
    int          obs_lat, obs_wc, obs_wk;
    logic        obs_id, obs_err;
    logic [31:0] obs_rd, obs_wa, obs_wd;

    always #5 m_clock = ~m_clock;

    dpram_port_arbiter #(.ADDR_W(32)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .ack1(ack1), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[9:2]];

    always @(posedge m_clock)
        if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

    // Drive one request for a single sampling edge, then record what the DUT does.
    task automatic run_one(input logic rid, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        @(posedge m_clock); #1;
        if (rid) begin req1 = 1'b1; we1 = w; size1 = sz; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1'b1; we0 = w; size0 = sz; addr0 = a; wdata0 = wd; end
        @(posedge m_clock); #1;
        req0 = 1'b0; req1 = 1'b0;
        obs_lat = 0; obs_wc = 0; obs_wk = 0;
        obs_id = 1'bx; obs_err = 1'bx; obs_rd = 'x; obs_wa = 'x; obs_wd = 'x;
        for (int k = 1; k <= 6; k++) begin
            @(negedge m_clock);
            if (mem_we) begin obs_wc++; obs_wk = k; obs_wa = mem_addr; obs_wd = mem_wdata; end
            if (obs_lat == 0 && (ack0 || ack1)) begin
                obs_lat = k;
                obs_id  = ack1;
                obs_err = ack1 ? err1 : err0;
                obs_rd  = ack1 ? rdata1 : rdata0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge m_clock); #1;
        p_reset = 1'b1;
        repeat (2) @(posedge m_clock);
        #1 p_reset = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
    endtask

    task automatic test_reset();
        p_reset = 1'b1;
        repeat (3) @(posedge m_clock);
        @(negedge m_clock);
        total++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || err0 !== 1'b0 || err1 !== 1'b0)
            $display("FAIL reset_ack ack0=%b ack1=%b err0=%b err1=%b required all 0", ack0, ack1, err0, err1);
        else passed++;
        total++;
        if (rdata0 !== 32'd0 || rdata1 !== 32'd0)
            $display("FAIL reset_rdata rdata0=%h rdata1=%h required 0", rdata0, rdata1);
        else passed++;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
            $display("FAIL reset_mem we=%b addr=%h wdata=%h required 0", mem_we, mem_addr, mem_wdata);
        else passed++;
        #1 p_reset = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
    endtask

    task automatic test_word_write_read();
        sb.push_back('{id: 1'b0, rdata: exp_rd0, err: 1'b0, lat: 2});
        run_one(1'b0, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_id !== e.id || obs_err !== e.err || obs_rd !== e.rdata)
            $display("FAIL ww_ack lat=%0d id=%b err=%b rdata=%h required lat=%0d id=%b err=%b rdata=%h",
                     obs_lat, obs_id, obs_err, obs_rd, e.lat, e.id, e.err, e.rdata);
        else passed++;
        total++;
        if (obs_wc !== 1 || obs_wk !== 1 || obs_wa !== 32'h100 || obs_wd !== 32'hDEADBEEF)
            $display("FAIL ww_mem count=%0d cyc=%0d addr=%h data=%h required 1 1 00000100 deadbeef",
                     obs_wc, obs_wk, obs_wa, obs_wd);
        else passed++;

        exp_rd1 = 32'hDEADBEEF;
        sb.push_back('{id: 1'b1, rdata: exp_rd1, err: 1'b0, lat: 2});
        run_one(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_id !== e.id || obs_err !== e.err || obs_rd !== e.rdata || obs_wc !== 0)
            $display("FAIL wr_ack lat=%0d id=%b err=%b rdata=%h we=%0d required lat=%0d id=%b err=%b rdata=%h we=0",
                     obs_lat, obs_id, obs_err, obs_rd, obs_wc, e.lat, e.id, e.err, e.rdata);
        else passed++;
    endtask

    task automatic test_byte_write();
        sb.push_back('{id: 1'b0, rdata: exp_rd0, err: 1'b0, lat: 3});
        run_one(1'b0, 1'b1, 2'b00, 32'h101, 32'h000000AA);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_id !== e.id || obs_err !== e.err || obs_rd !== e.rdata)
            $display("FAIL bw_ack lat=%0d id=%b err=%b rdata=%h required lat=%0d id=%b err=%b rdata=%h",
                     obs_lat, obs_id, obs_err, obs_rd, e.lat, e.id, e.err, e.rdata);
        else passed++;
        total++;
        if (obs_wc !== 1 || obs_wk !== 2 || obs_wa !== 32'h100 || obs_wd !== 32'hDEADAAEF)
            $display("FAIL bw_mem count=%0d cyc=%0d addr=%h data=%h required 1 2 00000100 deadaaef",
                     obs_wc, obs_wk, obs_wa, obs_wd);
        else passed++;

        exp_rd0 = 32'hDEADAAEF;
        sb.push_back('{id: 1'b0, rdata: exp_rd0, err: 1'b0, lat: 2});
        run_one(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_id !== e.id || obs_rd !== e.rdata)
            $display("FAIL bw_readback lat=%0d id=%b rdata=%h required lat=%0d id=%b rdata=%h",
                     obs_lat, obs_id, obs_rd, e.lat, e.id, e.rdata);
        else passed++;
    endtask

    task automatic test_sub_word_read();
        exp_rd0 = 32'h0000DEAD;
        sb.push_back('{id: 1'b0, rdata: exp_rd0, err: 1'b0, lat: 2});
        run_one(1'b0, 1'b0, 2'b01, 32'h102, 32'h0);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_err !== e.err || obs_rd !== e.rdata)
            $display("FAIL half_read lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h",
                     obs_lat, obs_err, obs_rd, e.lat, e.err, e.rdata);
        else passed++;

        exp_rd0 = 32'h000000DE;
        sb.push_back('{id: 1'b0, rdata: exp_rd0, err: 1'b0, lat: 2});
        run_one(1'b0, 1'b0, 2'b00, 32'h103, 32'h0);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_err !== e.err || obs_rd !== e.rdata)
            $display("FAIL byte_read lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h",
                     obs_lat, obs_err, obs_rd, e.lat, e.err, e.rdata);
        else passed++;
    endtask

    task automatic test_round_robin();
        int n, prev;
        logic both;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back('{id: 1'b0, rdata: 32'hDEADAAEF, err: 1'b0, lat: 0});
            else            sb.push_back('{id: 1'b1, rdata: 32'h12345678, err: 1'b0, lat: 0});
        end
        @(posedge m_clock); #1;
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 32'h100;
        req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 32'h104;
        n = 0; prev = -1; both = 1'b0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge m_clock);
            if (ack0 && ack1) both = 1'b1;
            else if (ack0 || ack1) begin
                e = sb.pop_front();
                total++;
                if (ack1 !== e.id || (ack1 ? rdata1 : rdata0) !== e.rdata || (prev >= 0 && c - prev != 3))
                    $display("FAIL rr_ack%0d id=%b rdata=%h gap=%0d required id=%b rdata=%h gap=3",
                             n, ack1, ack1 ? rdata1 : rdata0, c - prev, e.id, e.rdata);
                else passed++;
                prev = c;
                n++;
                if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (n !== 4 || both !== 1'b0)
            $display("FAIL rr_count acks=%0d both=%b required acks=4 both=0", n, both);
        else passed++;
        exp_rd0 = 32'hDEADAAEF; exp_rd1 = 32'h12345678;
        sb.delete();
        repeat (3) @(negedge m_clock);
    endtask

    task automatic test_misaligned();
        sb.push_back('{id: 1'b0, rdata: exp_rd0, err: 1'b1, lat: 2});
        run_one(1'b0, 1'b1, 2'b01, 32'h103, 32'h0000BEEF);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_id !== e.id || obs_err !== e.err || obs_rd !== e.rdata || obs_wc !== 0)
            $display("FAIL mis_half lat=%0d id=%b err=%b rdata=%h we=%0d required lat=%0d id=%b err=%b rdata=%h we=0",
                     obs_lat, obs_id, obs_err, obs_rd, obs_wc, e.lat, e.id, e.err, e.rdata);
        else passed++;

        sb.push_back('{id: 1'b1, rdata: exp_rd1, err: 1'b1, lat: 2});
        run_one(1'b1, 1'b0, 2'b11, 32'h100, 32'h0);
        e = sb.pop_front();
        total++;
        if (obs_lat !== e.lat || obs_id !== e.id || obs_err !== e.err || obs_rd !== e.rdata || obs_wc !== 0)
            $display("FAIL mis_size3 lat=%0d id=%b err=%b rdata=%h we=%0d required lat=%0d id=%b err=%b rdata=%h we=0",
                     obs_lat, obs_id, obs_err, obs_rd, obs_wc, e.lat, e.id, e.err, e.rdata);
        else passed++;
        total++;
        if (ram[64] !== 32'hDEADAAEF)
            $display("FAIL mis_ram word=%h required deadaaef", ram[64]);
        else passed++;
    endtask

    task automatic test_reset_mid_rmw();
        int acks, wes, n;
        logic first_id;
        @(posedge m_clock); #1;
        req0 = 1'b1; we0 = 1'b1; size0 = 2'b00; addr0 = 32'h100; wdata0 = 32'h55;
        @(posedge m_clock); #1;
        req0 = 1'b0;
        @(posedge m_clock); #1;
        p_reset = 1'b1;
        acks = 0; wes = 0;
        @(negedge m_clock);
        if (mem_we) wes++;
        if (ack0 || ack1) acks++;
        @(posedge m_clock); #1;
        p_reset = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge m_clock);
            if (mem_we) wes++;
            if (ack0 || ack1) acks++;
        end
        total++;
        if (wes !== 0 || acks !== 0)
            $display("FAIL rst_quiet mem_we=%0d acks=%0d required 0 0", wes, acks);
        else passed++;
        total++;
        if (ram[64] !== 32'hDEADAAEF)
            $display("FAIL rst_ram word=%h required deadaaef", ram[64]);
        else passed++;
        total++;
        if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1)
            $display("FAIL rst_rdata rdata0=%h rdata1=%h required 0 0", rdata0, rdata1);
        else passed++;

        sb.push_back('{id: 1'b0, rdata: 32'hDEADAAEF, err: 1'b0, lat: 0});
        sb.push_back('{id: 1'b1, rdata: 32'h12345678, err: 1'b0, lat: 0});
        @(posedge m_clock); #1;
        req0 = 1'b1; we0 = 1'b0; size0 = 2'b10; addr0 = 32'h100;
        req1 = 1'b1; we1 = 1'b0; size1 = 2'b10; addr1 = 32'h104;
        n = 0; first_id = 1'bx;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge m_clock);
            if (ack0 || ack1) begin
                e = sb.pop_front();
                total++;
                if (ack0 === ack1 || ack1 !== e.id || (ack1 ? rdata1 : rdata0) !== e.rdata)
                    $display("FAIL rst_tie%0d ack0=%b ack1=%b rdata=%h required id=%b rdata=%h",
                             n, ack0, ack1, ack1 ? rdata1 : rdata0, e.id, e.rdata);
                else passed++;
                n++;
                if (ack1) req1 = 1'b0;
                else      req0 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (n !== 2)
            $display("FAIL rst_tie_count acks=%0d required 2", n);
        else passed++;
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[65] = 32'h12345678;
        p_reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; size1 = 2'b00; addr1 = '0; wdata1 = '0;
        exp_rd0 = '0; exp_rd1 = '0;

        test_reset();
        test_word_write_read();
        test_byte_write();
        test_sub_word_read();
        test_round_robin();
        test_misaligned();
        test_reset_mid_rmw();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
Shares one port of the byte-addressed 32-bit dual-port RAM between two requesters, e.g. CPU load/store and a loader/DMA engine. Arbitration is round-robin with a req/ack handshake. Adds byte and halfword access on top of the RAM's full-word-only writes by doing a read-modify-write. Sits between the requesters and RAM port 2; port 1 stays dedicated to instruction fetch.

Parameters:
ADDR_W, 32, byte address width shared by requester and RAM addresses

Ports:
m_clock  input  1  clock; all state changes on its rising edge
p_reset  input  1  synchronous reset, active-high
req0  input  1  requester 0 transaction request
we0  input  1  requester 0 write (1) / read (0)
size0  input  2  00 byte, 01 half, 10 word, 11 reserved
addr0  input  ADDR_W  requester 0 byte address
wdata0  input  32  requester 0 write data, right-justified
rdata0  output  32  requester 0 read data, registered
ack0  output  1  requester 0 completion pulse
err0  output  1  requester 0 error flag, valid with ack0
req1, we1, size1, addr1, wdata1, rdata1, ack1, err1  same as above for requester 1
mem_addr  output  ADDR_W  RAM byte address, always word-aligned (bits [1:0]=0)
mem_wdata  output  32  RAM write word
mem_we  output  1  RAM write enable
mem_rdata  input  32  RAM read word, combinational from mem_addr

Behaviour:
- Interface: one clock, m_clock. Reset p_reset is synchronous and active-high.
- Reset values:
  - state=IDLE; rr_last=1, so requester 0 wins the first tie.
  - ack0/1=0, err0/1=0, rdata0/1=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the requester that is not rr_last.
  - On grant, latch id, we, size, addr and wdata; update rr_last; go to ACCESS.
  - Misalignment check uses the latched values. Misaligned means size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11. A misaligned request goes straight to DONE with err=1 and no RAM access.
- ACCESS:
  - mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - Read: the selected lane of mem_rdata is captured into rdata of the granted requester, zero-extended and right-justified. Byte lane is addr[1:0]; half lane is addr[1]. Word is returned as-is. Next state DONE.
  - Word write: mem_we=1, mem_wdata=wdata. Next state DONE.
  - Byte/half write: merge register = mem_rdata with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Next state WRITE.
- WRITE: mem_we=1, mem_wdata=merge register, same aligned mem_addr. Next state DONE.
- DONE: ack of the granted requester=1 for exactly one cycle, with err set as computed. Next state IDLE.
- mem_we is 1 only in ACCESS(word write) and WRITE, never otherwise.
- Outputs outside a transaction: mem_addr/mem_wdata hold 0 in IDLE and DONE.
- Latency, counted from req sampled in IDLE at cycle T:
  - read / word write / error: ack at T+2;
  - byte/half write: ack at T+3.
- Back-to-back: the earliest next grant is the IDLE cycle after DONE, so throughput is one transaction per 3 (or 4) cycles.
- Handshake:
  - Request fields are latched at grant. A requester may drop req after grant; the transaction still completes and acks.
  - req still high in the IDLE after its ack is treated as a new request.
  - rdata of a requester holds until its next read completes; writes and errors do not change rdata.
- Reset mid-operation: return to IDLE next cycle. No ack. A pending RMW write is dropped and the RAM is unchanged. rr_last is reset.
- The non-granted requester waits with no ack; starvation is impossible under round-robin.

Test Plan:
1. Reset, req0 word write 0xDEADBEEF @0x100 at T. Then req1 word read @0x100. Expected: ack0 at T+2; mem_we high exactly one cycle at T+1; ack1 with rdata1=0xDEADBEEF.
2. Word @0x100 = 0xDEADBEEF; req0 byte write 0xAA @0x101 at T. Expected: mem_we high only at T+2 with mem_addr=0x100, mem_wdata=0xDEADAAEF; ack0 at T+3; a word read then returns 0xDEADAAEF.
3. Half read @0x102 of 0xDEADAAEF; then byte read @0x103. Expected: rdata=0x0000DEAD, then 0x000000DE.
4. req0 and req1 held high continuously after reset, both issuing word reads. Expected: acks alternate ack0, ack1, ack0, ack1, spaced 3 cycles apart; never both in one cycle.
5. Half write @0x103 (misaligned) and size=11 read. Expected: ack with err=1 at T+2; mem_we never asserted; rdata unchanged.
6. Byte write started at T; p_reset asserted at T+2 (WRITE state). Expected: no mem_we, no ack; memory word unchanged; next req0 grant behaves as after reset, requester 0 winning a tie.
